// File: rtl/iob_cache_be_arbiter_pkg.sv
// Shared definitions for the cache back-end arbiter: FSM encoding and
// the helper that sizes the grant index.
package iob_cache_be_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_t;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_cache_rr_prio.sv
// Rotating-priority encoder: returns the first asserted request found when
// scanning from ptr_i upwards and wrapping around to 0.
module iob_cache_rr_prio #(
    parameter int N   = 2,
    parameter int N_W = 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [N_W-1:0] ptr_i,
    output logic [N_W-1:0] idx_o,
    output logic           any_o
);

    // Scan from the farthest slot back to ptr so the nearest hit wins last.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        idx_o = '0;
        any_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            int k;
            k = int'(ptr_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (req_i[k]) begin
                idx_o = N_W'(k);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Round-robin arbiter sharing one back-end IOB port between N requesters.
// One transaction in flight; the grant is held until write acceptance or
// read data return, so responses are routed by the held grant index.
module iob_cache_be_arbiter
    import iob_cache_be_arbiter_pkg::*;
#(
    parameter int N      = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_W    = idx_width(N)
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic [N-1:0]          m_valid_i,
    input  logic [N*ADDR_W-1:0]   m_addr_i,
    input  logic [N*DATA_W-1:0]   m_wdata_i,
    input  logic [N*DATA_W/8-1:0] m_wstrb_i,
    output logic [N-1:0]          m_ready_o,
    output logic [N-1:0]          m_rvalid_o,
    output logic [N*DATA_W-1:0]   m_rdata_o,
    output logic                  iob_valid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    input  logic                  iob_rvalid_i,
    input  logic [DATA_W-1:0]     iob_rdata_i
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t     state_q, state_d;
    logic [N_W-1:0] gnt_q, gnt_d;
    logic [N_W-1:0] ptr_q, ptr_d;

    logic [N_W-1:0]    pick_idx;
    logic              pick_any;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;

    iob_cache_rr_prio #(
        .N   (N),
        .N_W (N_W)
    ) u_prio (
        .req_i (m_valid_i),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Slot selected by the held grant; no per-requester copies are stored.
    always_comb begin
        sel_valid = m_valid_i[gnt_q];
        sel_addr  = m_addr_i[int'(gnt_q)*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata_i[int'(gnt_q)*DATA_W +: DATA_W];
        sel_wstrb = m_wstrb_i[int'(gnt_q)*STRB_W +: STRB_W];
    end

    // State, grant and pointer registers; reset and update share the clock enable.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                gnt_q   <= '0;
                ptr_q   <= '0;
            end else begin
                // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
                state_q <= state_d;
                gnt_q   <= gnt_d;
                ptr_q   <= ptr_d;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until the transaction ends.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!sel_valid) begin
                    // Requester withdrew before acceptance; do not advance the pointer.
                    state_d = ST_IDLE;
                end else if (iob_ready_i) begin
                    ptr_d   = (gnt_q == N_W'(N - 1)) ? '0 : gnt_q + N_W'(1);
                    state_d = (sel_wstrb == '0) ? ST_RDWAIT : ST_IDLE;
                end
            end
            ST_RDWAIT: begin
                if (iob_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: drive the shared port only in GRANT, route rvalid only in RDWAIT.
    always_comb begin
        iob_valid_o = 1'b0;
        iob_addr_o  = '0;
        iob_wdata_o = '0;
        iob_wstrb_o = '0;
        m_ready_o   = '0;
        m_rvalid_o  = '0;
        unique case (state_q)
            ST_GRANT: begin
                iob_valid_o      = sel_valid;
                iob_addr_o       = sel_addr;
                iob_wdata_o      = sel_wdata;
                iob_wstrb_o      = sel_wstrb;
                m_ready_o[gnt_q] = iob_ready_i;
            end
            ST_RDWAIT: begin
                m_rvalid_o[gnt_q] = iob_rvalid_i;
            end
            default: begin
            end
        endcase
    end

    assign m_rdata_o = {N{iob_rdata_i}};

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Directed self-checking bench: an N=2 instance for the main scenarios and
// an N=4 instance for the rotate-priority wrap case.
module tb_iob_cache_be_arbiter;
    import iob_cache_be_arbiter_pkg::*;

    logic clk = 1'b0;
    logic cke = 1'b1;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- N=2 instance ----------------
    logic [1:0]   a_valid = '0;
    logic [63:0]  a_addr  = '0;
    logic [63:0]  a_wdata = '0;
    logic [7:0]   a_wstrb = '0;
    logic [1:0]   a_ready_o, a_rvalid_o;
    logic [63:0]  a_rdata_o;
    logic         a_iob_valid;
    logic [31:0]  a_iob_addr, a_iob_wdata;
    logic [3:0]   a_iob_wstrb;
    logic         a_iob_ready  = 1'b0;
    logic         a_iob_rvalid = 1'b0;
    logic [31:0]  a_iob_rdata  = '0;

    iob_cache_be_arbiter #(.N(2), .ADDR_W(32), .DATA_W(32)) a_dut (
        .clk_i       (clk),
        .cke_i       (cke),
        .rst_i       (rst),
        .m_valid_i   (a_valid),
        .m_addr_i    (a_addr),
        .m_wdata_i   (a_wdata),
        .m_wstrb_i   (a_wstrb),
        .m_ready_o   (a_ready_o),
        .m_rvalid_o  (a_rvalid_o),
        .m_rdata_o   (a_rdata_o),
        .iob_valid_o (a_iob_valid),
        .iob_addr_o  (a_iob_addr),
        .iob_wdata_o (a_iob_wdata),
        .iob_wstrb_o (a_iob_wstrb),
        .iob_ready_i (a_iob_ready),
        .iob_rvalid_i(a_iob_rvalid),
        .iob_rdata_i (a_iob_rdata)
    );

    // ---------------- N=4 instance ----------------
    logic [3:0]   b_valid = '0;
    logic [127:0] b_addr  = '0;
    logic [127:0] b_wdata = '0;
    logic [15:0]  b_wstrb = '0;
    logic [3:0]   b_ready_o, b_rvalid_o;
    logic [127:0] b_rdata_o;
    logic         b_iob_valid;
    logic [31:0]  b_iob_addr, b_iob_wdata;
    logic [3:0]   b_iob_wstrb;
    logic         b_iob_ready  = 1'b0;
    logic         b_iob_rvalid = 1'b0;
    logic [31:0]  b_iob_rdata  = '0;

    iob_cache_be_arbiter #(.N(4), .ADDR_W(32), .DATA_W(32)) b_dut (
        .clk_i       (clk),
        .cke_i       (cke),
        .rst_i       (rst),
        .m_valid_i   (b_valid),
        .m_addr_i    (b_addr),
        .m_wdata_i   (b_wdata),
        .m_wstrb_i   (b_wstrb),
        .m_ready_o   (b_ready_o),
        .m_rvalid_o  (b_rvalid_o),
        .m_rdata_o   (b_rdata_o),
        .iob_valid_o (b_iob_valid),
        .iob_addr_o  (b_iob_addr),
        .iob_wdata_o (b_iob_wdata),
        .iob_wstrb_o (b_iob_wstrb),
        .iob_ready_i (b_iob_ready),
        .iob_rvalid_i(b_iob_rvalid),
        .iob_rdata_i (b_iob_rdata)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        // ---------- reset ----------
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rst_iob_valid", 64'(a_iob_valid), 64'd0);
        check("rst_m_ready",   64'(a_ready_o),   64'd0);
        check("rst_m_rvalid",  64'(a_rvalid_o),  64'd0);
        check("rst_iob_addr",  64'(a_iob_addr),  64'd0);

        // ---------- 1: m0 read 0x100, rdata 0xCAFE ----------
        a_valid       = 2'b01;
        a_addr[31:0]  = 32'h100;
        a_wstrb[3:0]  = 4'h0;
        settle();
        check("t1_idle_no_req", 64'(a_iob_valid), 64'd0);
        tick();                               // IDLE -> GRANT (gnt 0)
        a_iob_ready = 1'b1;
        settle();
        check("t1_iob_valid", 64'(a_iob_valid), 64'd1);
        check("t1_iob_addr",  64'(a_iob_addr),  64'h100);
        check("t1_m_ready",   64'(a_ready_o),   64'b01);
        tick();                               // GRANT -> RDWAIT
        a_valid     = 2'b00;
        a_iob_ready = 1'b0;
        settle();
        check("t1_rdwait_ready",  64'(a_ready_o),   64'd0);
        check("t1_rdwait_valid",  64'(a_iob_valid), 64'd0);
        check("t1_rdwait_rvalid", 64'(a_rvalid_o),  64'd0);
        tick();
        a_iob_rvalid = 1'b1;
        a_iob_rdata  = 32'hCAFE;
        settle();
        check("t1_m_rvalid", 64'(a_rvalid_o),      64'b01);
        check("t1_rdata0",   64'(a_rdata_o[31:0]), 64'hCAFE);
        tick();                               // RDWAIT -> IDLE
        a_iob_rvalid = 1'b0;
        settle();
        check("t1_end_rvalid", 64'(a_rvalid_o),    64'd0);
        check("t1_end_state",  64'(a_dut.state_q), 64'(ST_IDLE));
        check("t1_end_ptr",    64'(a_dut.ptr_q),   64'd1);

        // ---------- 2: both writing continuously, grants alternate ----------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_addr  = {32'hB0, 32'hA0};
        a_wdata = {32'h2222, 32'h1111};
        a_wstrb = 8'hFF;
        a_valid = 2'b11;
        a_iob_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            settle();
            check("t2_idle_valid", 64'(a_iob_valid), 64'd0);
            tick();                           // IDLE -> GRANT
            settle();
            check("t2_grant", 64'(a_ready_o),  (t % 2 == 0) ? 64'b01 : 64'b10);
            check("t2_addr",  64'(a_iob_addr), (t % 2 == 0) ? 64'hA0 : 64'hB0);
            tick();                           // GRANT -> IDLE
            check("t2_ptr",   64'(a_dut.ptr_q), (t % 2 == 0) ? 64'd1 : 64'd0);
        end

        // ---------- 5: ready withheld 5 cycles in GRANT ----------
        a_iob_ready = 1'b0;
        settle();
        tick();                               // IDLE -> GRANT (gnt 0, ptr 0)
        for (int t = 0; t < 5; t++) begin
            settle();
            check("t5_iob_valid", 64'(a_iob_valid), 64'd1);
            check("t5_iob_addr",  64'(a_iob_addr),  64'hA0);
            check("t5_iob_wdata", 64'(a_iob_wdata), 64'h1111);
            check("t5_m_ready",   64'(a_ready_o),   64'd0);
            tick();
        end
        a_iob_ready = 1'b1;
        settle();
        check("t5_accept", 64'(a_ready_o), 64'b01);
        tick();                               // GRANT -> IDLE, ptr 1
        a_valid     = 2'b00;
        a_iob_ready = 1'b0;
        settle();
        check("t5_ptr", 64'(a_dut.ptr_q), 64'd1);

        // ---------- withdraw before ready ----------
        a_valid = 2'b10;
        tick();                               // IDLE -> GRANT (gnt 1)
        a_valid = 2'b00;
        settle();
        check("wd_iob_valid", 64'(a_iob_valid), 64'd0);
        tick();                               // GRANT -> IDLE, ptr unchanged
        settle();
        check("wd_state", 64'(a_dut.state_q), 64'(ST_IDLE));
        check("wd_ptr",   64'(a_dut.ptr_q),   64'd1);

        // ---------- 6: cke low during RDWAIT ----------
        a_valid        = 2'b10;
        a_wstrb[7:4]   = 4'h0;
        a_addr[63:32]  = 32'h300;
        tick();                               // IDLE -> GRANT (gnt 1)
        a_iob_ready = 1'b1;
        settle();
        check("t6_addr", 64'(a_iob_addr), 64'h300);
        tick();                               // GRANT -> RDWAIT, ptr 0
        a_valid     = 2'b00;
        a_iob_ready = 1'b0;
        cke         = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            settle();
            check("t6_hold_state",  64'(a_dut.state_q), 64'(ST_RDWAIT));
            check("t6_hold_rvalid", 64'(a_rvalid_o),    64'd0);
        end
        cke          = 1'b1;
        a_iob_rvalid = 1'b1;
        a_iob_rdata  = 32'h1234;
        settle();
        check("t6_m_rvalid", 64'(a_rvalid_o),       64'b10);
        check("t6_rdata1",   64'(a_rdata_o[63:32]), 64'h1234);
        tick();                               // RDWAIT -> IDLE
        a_iob_rvalid = 1'b0;
        settle();
        check("t6_end_state", 64'(a_dut.state_q), 64'(ST_IDLE));

        // ---------- 4: reset during RDWAIT, late rvalid dropped ----------
        a_valid      = 2'b01;
        a_wstrb[3:0] = 4'h0;
        tick();                               // IDLE -> GRANT (gnt 0)
        a_iob_ready = 1'b1;
        tick();                               // GRANT -> RDWAIT, ptr 1
        a_valid     = 2'b00;
        a_iob_ready = 1'b0;
        settle();
        check("t4_in_rdwait", 64'(a_dut.state_q), 64'(ST_RDWAIT));
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        a_iob_rvalid = 1'b1;
        settle();
        check("t4_m_rvalid",  64'(a_rvalid_o),      64'd0);
        check("t4_iob_valid", 64'(a_iob_valid),     64'd0);
        check("t4_state",     64'(a_dut.state_q),   64'(ST_IDLE));
        check("t4_ptr",       64'(a_dut.ptr_q),     64'd0);
        tick();
        a_iob_rvalid = 1'b0;
        settle();
        check("t4_stray_state", 64'(a_dut.state_q), 64'(ST_IDLE));

        // ---------- 3: N=4 rotate priority with wrap ----------
        b_addr  = {32'h4003, 32'h4002, 32'h4001, 32'h4000};
        b_wstrb = 16'hFFFF;
        b_valid = 4'b0010;
        b_iob_ready = 1'b1;
        tick();                               // IDLE -> GRANT (gnt 1)
        settle();
        check("t3_first_gnt", 64'(b_ready_o), 64'b0010);
        tick();                               // GRANT -> IDLE, ptr 2
        b_valid = 4'b1010;
        settle();
        check("t3_ptr2", 64'(b_dut.ptr_q), 64'd2);
        tick();                               // IDLE -> GRANT (gnt 3)
        settle();
        check("t3_gnt3",  64'(b_ready_o),  64'b1000);
        check("t3_addr3", 64'(b_iob_addr), 64'h4003);
        tick();                               // GRANT -> IDLE, ptr wraps to 0
        settle();
        check("t3_ptr0", 64'(b_dut.ptr_q), 64'd0);
        tick();                               // IDLE -> GRANT (gnt 1)
        settle();
        check("t3_gnt1",  64'(b_ready_o),  64'b0010);
        check("t3_addr1", 64'(b_iob_addr), 64'h4001);
        tick();
        b_valid     = 4'b0000;
        b_iob_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
